// File: rtl/arb_mux_pkg.sv
// rtl/arb_mux_pkg.sv - shared constants and helpers for the arbitrating output mux
package arb_mux_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Width of a channel index; never narrower than one bit.
  function automatic int selw(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin / fixed-priority grant with encoded index
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int MODE = ARB_RR,
  parameter int SELW = selw(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  grant,
  output logic [SELW-1:0] idx
);

  logic [NCH-1:0] mask;
  logic [NCH-1:0] masked;
  logic [NCH-1:0] pick;

  // Requests at or above ptr win first; if none, wrap to the lowest requester.
  always_comb begin
    mask = '1;
    if (MODE == ARB_RR) begin
      mask = {NCH{1'b1}} << ptr;
    end
    masked = req & mask;
    pick   = (|masked) ? masked : req;
    grant  = pick & (~pick + NCH'(1));
  end

  always_comb begin
    idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) begin
        idx = SELW'(i);
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - N-channel arbiter feeding a single registered output word
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int MODE  = ARB_RR,
  localparam int SELW = selw(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  ptr_nxt;
  logic [SELW-1:0]  gidx;
  logic [NCH-1:0]   grant;
  logic [WIDTH-1:0] gdata;
  logic             load;
  logic             any_req;

  rr_arbiter #(
    .NCH  (NCH),
    .MODE (MODE),
    .SELW (SELW)
  ) u_arb (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx)
  );

  assign load    = !out_valid || out_ready;
  assign any_req = |in_valid;

  // reset gates in_ready so the ports read zero while reset is held, clock or not.
  assign in_ready = (reset || !load) ? '0 : grant;

  assign ptr_nxt = (gidx == SELW'(NCH - 1)) ? '0 : gidx + SELW'(1);

  // Data select feeds only the output register, never a port directly.
  always_comb begin
    gdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) begin
        gdata = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (any_req) begin
        out_valid <= 1'b1;
        out_data  <= gdata;
        out_sel   <= gidx;
        if (MODE == ARB_RR) begin
          ptr <= ptr_nxt;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// tb/tb_arb_mux.sv - self-checking bench for arb_mux in round-robin and fixed-priority modes
module tb_arb_mux;
  import arb_mux_pkg::*;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic           out_ready;

  logic [N-1:0] rdy_rr, rdy_fx;
  logic         ov_rr, ov_fx;
  logic [W-1:0] od_rr, od_fx;
  logic [1:0]   os_rr, os_fx;

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(W), .NCH(N), .MODE(ARB_RR)) dut_rr (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_rr), .out_valid(ov_rr), .out_data(od_rr), .out_sel(os_rr),
    .out_ready(out_ready)
  );

  arb_mux #(.WIDTH(W), .NCH(N), .MODE(ARB_FIXED)) dut_fx (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_fx), .out_valid(ov_fx), .out_data(od_fx), .out_sel(os_fx),
    .out_ready(out_ready)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: index 0 = round-robin DUT, index 1 = fixed-priority DUT.
  bit           m_v[2];
  logic [W-1:0] m_d[2];
  int           m_s[2];
  int           m_p[2];
  int           g_arr[2];
  logic [N-1:0] exp_rdy[2];
  logic [N-1:0] obs_rdy[2];
  logic [W-1:0] d[N];

  function automatic int winner(input int mode, input int p, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (mode == 0) ? (p + k) % N : k;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic drive(input logic [N-1:0] v);
    in_valid = v;
    in_data  = {d[3], d[2], d[1], d[0]};
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_v[m] = 0; m_d[m] = '0; m_s[m] = 0; m_p[m] = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      g_arr[m]   = winner(m, m_p[m], in_valid);
      exp_rdy[m] = (g_arr[m] >= 0 && (!m_v[m] || out_ready)) ? (N'(1) << g_arr[m]) : '0;
    end
    obs_rdy[0] = rdy_rr;
    obs_rdy[1] = rdy_fx;
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (!m_v[m] || out_ready) begin
        if (g_arr[m] >= 0) begin
          m_v[m] = 1;
          m_d[m] = d[g_arr[m]];
          m_s[m] = g_arr[m];
          if (m == 0) m_p[m] = (g_arr[m] + 1) % N;
        end else begin
          m_v[m] = 0;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) d[i] = '0;
    drive('0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    d[0] = 8'h12; d[1] = 8'h34; d[2] = 8'h56; d[3] = 8'h78;
    drive(4'b1111);
    out_ready = 1'b1;
    #1;
    total++;
    if ({ov_rr, od_rr, os_rr, rdy_rr} !== 15'd0) begin
      bad++;
      $display("FAIL reset_rr got v=%b d=%h s=%0d rdy=%b want all 0", ov_rr, od_rr, os_rr, rdy_rr);
    end
    total++;
    if ({ov_fx, od_fx, os_fx, rdy_fx} !== 15'd0) begin
      bad++;
      $display("FAIL reset_fx got v=%b d=%h s=%0d rdy=%b want all 0", ov_fx, od_fx, os_fx, rdy_fx);
    end
    do_reset();
  endtask

  task automatic test_round_robin();
    int exp_sel[5] = '{0, 1, 2, 3, 0};
    do_reset();
    d[0] = 8'hA0; d[1] = 8'hA1; d[2] = 8'hA2; d[3] = 8'hA3;
    drive(4'b1111);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (ov_rr !== 1'b1 || os_rr !== 2'(exp_sel[i]) || od_rr !== 8'hA0 + 8'(exp_sel[i])) begin
        bad++;
        $display("FAIL rr_seq[%0d] got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                 i, ov_rr, os_rr, od_rr, exp_sel[i], 8'hA0 + 8'(exp_sel[i]));
      end
      total++;
      if (ov_fx !== 1'b1 || os_fx !== 2'd0 || od_fx !== 8'hA0) begin
        bad++;
        $display("FAIL fx_all_req[%0d] got v=%b s=%0d d=%h want v=1 s=0 d=a0", i, ov_fx, os_fx, od_fx);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    d[3] = 8'h5C;
    drive(4'b1000);
    out_ready = 1'b1;
    step();
    total++;
    if (ov_rr !== 1'b1 || os_rr !== 2'd3 || od_rr !== 8'h5C || obs_rdy[0] !== 4'b1000) begin
      bad++;
      $display("FAIL wrap got v=%b s=%0d d=%h rdy=%b want v=1 s=3 d=5c rdy=1000",
               ov_rr, os_rr, od_rr, obs_rdy[0]);
    end
    d[0] = 8'h01; d[1] = 8'h02; d[2] = 8'h03;
    drive(4'b1111);
    step();
    total++;
    if (os_rr !== 2'd0 || od_rr !== 8'h01) begin
      bad++;
      $display("FAIL wrap_ptr got s=%0d d=%h want s=0 d=01", os_rr, od_rr);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    d[0] = 8'h11;
    drive(4'b0001);
    out_ready = 1'b0;
    step();
    total++;
    if (ov_rr !== 1'b1 || od_rr !== 8'h11) begin
      bad++;
      $display("FAIL bp_load got v=%b d=%h want v=1 d=11", ov_rr, od_rr);
    end
    d[1] = 8'h22; d[2] = 8'h33;
    drive(4'b0110);
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (obs_rdy[0] !== 4'b0000 || ov_rr !== 1'b1 || od_rr !== 8'h11 || os_rr !== 2'd0) begin
        bad++;
        $display("FAIL bp_hold[%0d] got rdy=%b v=%b d=%h s=%0d want rdy=0000 v=1 d=11 s=0",
                 i, obs_rdy[0], ov_rr, od_rr, os_rr);
      end
    end
    out_ready = 1'b1;
    step();
    total++;
    if (obs_rdy[0] !== 4'b0010 || ov_rr !== 1'b1 || od_rr !== 8'h22 || os_rr !== 2'd1) begin
      bad++;
      $display("FAIL bp_release got rdy=%b v=%b d=%h s=%0d want rdy=0010 v=1 d=22 s=1",
               obs_rdy[0], ov_rr, od_rr, os_rr);
    end
  endtask

  task automatic test_fixed();
    do_reset();
    d[0] = 8'hF0; d[1] = 8'hF1; d[2] = 8'hF2; d[3] = 8'hF3;
    drive(4'b1010);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (obs_rdy[1] !== 4'b0010 || os_fx !== 2'd1 || od_fx !== 8'hF1) begin
        bad++;
        $display("FAIL fixed[%0d] got rdy=%b s=%0d d=%h want rdy=0010 s=1 d=f1",
                 i, obs_rdy[1], os_fx, od_fx);
      end
      total++;
      if (os_rr !== ((i % 2 == 0) ? 2'd1 : 2'd3)) begin
        bad++;
        $display("FAIL rr_alt[%0d] got s=%0d want s=%0d", i, os_rr, (i % 2 == 0) ? 1 : 3);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    d[2] = 8'hE7;
    drive(4'b0100);
    out_ready = 1'b1;
    step();
    total++;
    if (ov_rr !== 1'b1 || od_rr !== 8'hE7 || os_rr !== 2'd2) begin
      bad++;
      $display("FAIL single_load got v=%b d=%h s=%0d want v=1 d=e7 s=2", ov_rr, od_rr, os_rr);
    end
    drive(4'b0000);
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (ov_rr !== 1'b0 || od_rr !== 8'hE7 || os_rr !== 2'd2) begin
        bad++;
        $display("FAIL single_drain[%0d] got v=%b d=%h s=%0d want v=0 d=e7 s=2", i, ov_rr, od_rr, os_rr);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    d[0] = 8'h9A; d[1] = 8'h9B; d[2] = 8'h9C; d[3] = 8'h9D;
    drive(4'b1111);
    out_ready = 1'b0;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({ov_rr, od_rr, os_rr, rdy_rr} !== 15'd0) begin
      bad++;
      $display("FAIL mid_reset got v=%b d=%h s=%0d rdy=%b want all 0", ov_rr, od_rr, os_rr, rdy_rr);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    total++;
    if (obs_rdy[0] !== 4'b0001 || ov_rr !== 1'b1 || od_rr !== 8'h9A || os_rr !== 2'd0) begin
      bad++;
      $display("FAIL after_reset got rdy=%b v=%b d=%h s=%0d want rdy=0001 v=1 d=9a s=0",
               obs_rdy[0], ov_rr, od_rr, os_rr);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] od[2];
    logic [1:0]   os[2];
    logic         ov[2];
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) d[i] = 8'($urandom);
      drive(N'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      ov[0] = ov_rr; od[0] = od_rr; os[0] = os_rr;
      ov[1] = ov_fx; od[1] = od_fx; os[1] = os_fx;
      for (int m = 0; m < 2; m++) begin
        total++;
        if (obs_rdy[m] !== exp_rdy[m] || ov[m] !== m_v[m] || od[m] !== m_d[m] || os[m] !== 2'(m_s[m])) begin
          bad++;
          $display("FAIL random[%0d] mode=%0d got rdy=%b v=%b d=%h s=%0d want rdy=%b v=%b d=%h s=%0d",
                   c, m, obs_rdy[m], ov[m], od[m], os[m], exp_rdy[m], m_v[m], m_d[m], m_s[m]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    in_valid = '0;
    in_data = '0;
    test_reset();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_fixed();
    test_single();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
